// File: rtl/cdc_handshake_rx.sv
// Destination-side endpoint of a 4-phase req/ack clock-domain crossing.
// The source request level is synchronized into clk_dest. The source bus is
// captured once per request and offered downstream as a valid/ready word.
// The acknowledge level goes back to the source once the consumer takes it.
module cdc_handshake_rx #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic              clk_dest,
  input  logic              rst_n,
  input  logic              src_req,
  input  logic [DATA_W-1:0] src_data,
  output logic              dst_ack,
  output logic              dst_valid,
  output logic [DATA_W-1:0] dst_data,
  input  logic              dst_ready,
  output logic              proto_err,
  output logic [CNT_W-1:0]  xfer_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    ACK  = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   req_s;

  state_t                 state_q, state_d;
  logic                   dst_ack_q, dst_ack_d;
  logic                   dst_valid_q, dst_valid_d;
  logic [DATA_W-1:0]      dst_data_q, dst_data_d;
  logic                   proto_err_q, proto_err_d;
  logic [CNT_W-1:0]       xfer_count_q, xfer_count_d;

  // Plain shift chain for the request level; the FSM sees only the last stage
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], src_req};
  end

  assign req_s = sync_q[SYNC_STAGES-1];

  // Synchronizer flops, cleared asynchronously so a reset never leaves a stale request
  always_ff @(posedge clk_dest or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  // Handshake sequencing: capture on request, deliver the word, ack, and wait for the request to drop
  always_comb begin
    state_d      = state_q;
    dst_ack_d    = dst_ack_q;
    dst_valid_d  = dst_valid_q;
    dst_data_d   = dst_data_q;
    proto_err_d  = proto_err_q;
    xfer_count_d = xfer_count_q;

    unique case (state_q)
      IDLE: begin
        dst_valid_d = 1'b0;
        dst_ack_d   = 1'b0;
        if (req_s) begin
          dst_data_d  = src_data;
          dst_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end

      HOLD: begin
        if (!req_s) begin
          proto_err_d = 1'b1;
        end
        if (dst_ready) begin
          dst_valid_d = 1'b0;
          dst_ack_d   = 1'b1;
          state_d     = ACK;
        end
      end

      ACK: begin
        if (!req_s) begin
          dst_ack_d    = 1'b0;
          xfer_count_d = xfer_count_q + CNT_W'(1);
          state_d      = IDLE;
        end
      end

      default: begin
        dst_valid_d = 1'b0;
        dst_ack_d   = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and registered outputs; dst_ack leaves the block straight from its flop
  always_ff @(posedge clk_dest or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      dst_ack_q    <= 1'b0;
      dst_valid_q  <= 1'b0;
      dst_data_q   <= '0;
      proto_err_q  <= 1'b0;
      xfer_count_q <= '0;
    end else begin
      state_q      <= state_d;
      dst_ack_q    <= dst_ack_d;
      dst_valid_q  <= dst_valid_d;
      dst_data_q   <= dst_data_d;
      proto_err_q  <= proto_err_d;
      xfer_count_q <= xfer_count_d;
    end
  end

  assign dst_ack    = dst_ack_q;
  assign dst_valid  = dst_valid_q;
  assign dst_data   = dst_data_q;
  assign proto_err  = proto_err_q;
  assign xfer_count = xfer_count_q;

endmodule

// File: tb/tb_cdc_handshake_rx.sv
// Self-checking bench for cdc_handshake_rx. The bench plays the source domain
// and the downstream consumer with randomized data, backpressure and request
// withdrawals. Expected timing comes from the edge-count latency rules.
// A second instance with a 2-bit counter exercises counter wrap.
module tb_cdc_handshake_rx;

  localparam int DATA_W = 8;
  localparam int S      = 2;
  localparam int CNT_W  = 16;
  localparam int WRAP_W = 2;

  logic              clkDest  = 1'b0;
  logic              rstN     = 1'b0;
  logic              srcReq   = 1'b0;
  logic              dstReady = 1'b0;
  logic [DATA_W-1:0] srcData  = '0;

  logic              dstAck, dstValid, protoErr;
  logic [DATA_W-1:0] dstData;
  logic [CNT_W-1:0]  xferCount;

  logic              wAck, wValid, wProto;
  logic [DATA_W-1:0] wData;
  logic [WRAP_W-1:0] wCount;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;
  int expCount = 0;
  bit expProto = 1'b0;

  cdc_handshake_rx #(.DATA_W(DATA_W), .SYNC_STAGES(S), .CNT_W(CNT_W)) dut (
    .clk_dest(clkDest), .rst_n(rstN), .src_req(srcReq), .src_data(srcData),
    .dst_ack(dstAck), .dst_valid(dstValid), .dst_data(dstData),
    .dst_ready(dstReady), .proto_err(protoErr), .xfer_count(xferCount)
  );

  cdc_handshake_rx #(.DATA_W(DATA_W), .SYNC_STAGES(S), .CNT_W(WRAP_W)) dutWrap (
    .clk_dest(clkDest), .rst_n(rstN), .src_req(srcReq), .src_data(srcData),
    .dst_ack(wAck), .dst_valid(wValid), .dst_data(wData),
    .dst_ready(dstReady), .proto_err(wProto), .xfer_count(wCount)
  );

  // Free-running destination clock, 10 time-unit period
  always #5 clkDest = ~clkDest;

  // Abort guard so a stuck run still reports and ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, actual, expected, $time);
    end
  endtask

  // One clock edge, then settle so outputs are sampled away from the edge
  task automatic tick();
    @(posedge clkDest);
    cycle++;
    #1;
  endtask

  // One complete 4-phase transfer. readyDelay is the number of cycles the consumer
  // stalls after the word appears. violate withdraws the request right after capture.
  task automatic applyStimulus(input logic [DATA_W-1:0] word, input int readyDelay, input bit violate);
    int  n;
    int  m;
    int  dropEdge;
    bit  dropped;
    dropped = 1'b0;
    n       = 0;

    srcData  = word;
    srcReq   = 1'b1;
    dstReady = (readyDelay == 0) ? 1'b1 : 1'($urandom_range(0, 1));

    for (int i = 0; i < S; i++) begin
      tick();
      checkOutput("valid_latency", {31'b0, dstValid}, 32'd0);
    end
    tick();
    checkOutput("valid_rise", {31'b0, dstValid}, 32'd1);
    checkOutput("data_capture", {24'b0, dstData}, {24'b0, word});
    checkOutput("ack_low_on_valid", {31'b0, dstAck}, 32'd0);
    checkOutput("wrap_valid", {31'b0, wValid}, 32'd1);
    checkOutput("wrap_data", {24'b0, wData}, {24'b0, word});

    if (violate) begin
      srcReq  = 1'b0;
      dropped = 1'b1;
      n       = cycle + 1;
    end

    if (readyDelay > 0) begin
      dstReady = 1'b0;
      for (int i = 0; i < readyDelay; i++) begin
        srcData = DATA_W'($urandom);
        tick();
        checkOutput("hold_valid", {31'b0, dstValid}, 32'd1);
        checkOutput("hold_data", {24'b0, dstData}, {24'b0, word});
        checkOutput("hold_ack", {31'b0, dstAck}, 32'd0);
      end
      dstReady = 1'b1;
    end

    tick();
    m = cycle;
    checkOutput("accept_valid", {31'b0, dstValid}, 32'd0);
    checkOutput("accept_ack", {31'b0, dstAck}, 32'd1);

    // The withdrawal is only visible to the block once it has crossed the synchronizer.
    // It counts as a violation if that happens while the word is still waiting.
    if (dropped && (n + S <= m)) expProto = 1'b1;

    dstReady = 1'($urandom_range(0, 1));
    if (!dropped) begin
      repeat ($urandom_range(0, 3)) begin
        tick();
        checkOutput("ack_held", {31'b0, dstAck}, 32'd1);
        checkOutput("ack_phase_valid", {31'b0, dstValid}, 32'd0);
      end
      srcReq = 1'b0;
      n      = cycle + 1;
    end

    dropEdge = (n + S > m + 1) ? (n + S) : (m + 1);
    while (cycle < dropEdge) begin
      tick();
      if (cycle < dropEdge) checkOutput("ack_wait", {31'b0, dstAck}, 32'd1);
    end
    expCount++;
    checkOutput("ack_fall", {31'b0, dstAck}, 32'd0);
    checkOutput("xfer_count", {16'b0, xferCount}, 32'(expCount % (1 << CNT_W)));
    checkOutput("wrap_count", {30'b0, wCount}, 32'(expCount % (1 << WRAP_W)));
    checkOutput("proto_err", {31'b0, protoErr}, {31'b0, expProto});
    checkOutput("wrap_proto", {31'b0, wProto}, {31'b0, expProto});
    checkOutput("wrap_ack", {31'b0, wAck}, 32'd0);

    repeat ($urandom_range(0, 3)) begin
      dstReady = 1'($urandom_range(0, 1));
      tick();
      checkOutput("idle_valid", {31'b0, dstValid}, 32'd0);
      checkOutput("idle_ack", {31'b0, dstAck}, 32'd0);
    end
    dstReady = 1'b0;
  endtask

  // Main sequence: reset, directed transfers, violations, random traffic, mid-transfer reset
  initial begin
    rstN = 1'b0;
    #2;
    checkOutput("reset_ack", {31'b0, dstAck}, 32'd0);
    checkOutput("reset_valid", {31'b0, dstValid}, 32'd0);
    checkOutput("reset_data", {24'b0, dstData}, 32'd0);
    checkOutput("reset_proto", {31'b0, protoErr}, 32'd0);
    checkOutput("reset_count", {16'b0, xferCount}, 32'd0);
    tick();
    tick();
    rstN = 1'b1;
    tick();

    applyStimulus(8'hA5, 0, 1'b0);
    applyStimulus(8'h5A, 10, 1'b0);
    for (int i = 1; i <= 5; i++) applyStimulus(DATA_W'(i), 0, 1'b0);
    checkOutput("b2b_no_proto", {31'b0, protoErr}, 32'd0);

    applyStimulus(8'hC3, S + 3, 1'b1);
    checkOutput("violation_flag", {31'b0, protoErr}, 32'd1);
    applyStimulus(8'h77, 2, 1'b0);
    checkOutput("violation_sticky", {31'b0, protoErr}, 32'd1);

    for (int i = 0; i < 30; i++) begin
      applyStimulus(DATA_W'($urandom), int'($urandom_range(0, 6)), ($urandom_range(0, 5) == 0));
    end

    srcData  = 8'h3C;
    srcReq   = 1'b1;
    dstReady = 1'b0;
    repeat (S + 1) tick();
    checkOutput("pre_reset_valid", {31'b0, dstValid}, 32'd1);
    #3;
    rstN = 1'b0;
    #1;
    checkOutput("async_reset_valid", {31'b0, dstValid}, 32'd0);
    checkOutput("async_reset_ack", {31'b0, dstAck}, 32'd0);
    checkOutput("async_reset_data", {24'b0, dstData}, 32'd0);
    checkOutput("async_reset_count", {16'b0, xferCount}, 32'd0);
    checkOutput("async_reset_proto", {31'b0, protoErr}, 32'd0);
    checkOutput("async_reset_wrap", {30'b0, wCount}, 32'd0);
    srcReq = 1'b0;
    expCount = 0;
    expProto = 1'b0;
    tick();
    tick();
    rstN = 1'b1;
    tick();
    tick();
    checkOutput("post_reset_idle", {31'b0, dstValid}, 32'd0);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(DATA_W'($urandom), int'($urandom_range(0, 4)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cdc_handshake_rx.md
Name: cdc_handshake_rx

Overview:
- Destination-side endpoint of a 4-phase req/ack multi-bit clock-domain crossing.
- The source domain drives a level request `src_req` and holds `src_data` stable.
- This block synchronizes `src_req` into `clk_dest`, captures the bus and presents it as a valid/ready stream.
- It returns a level `dst_ack` to the source domain once the local consumer has accepted the word.

Parameters:
- DATA_W, 8, width of transferred word.
- SYNC_STAGES, 2, flop stages on `src_req` synchronizer; legal range >=2.
- CNT_W, 16, width of completed-transfer counter.

Ports:
- clk_dest  in  1  destination-domain clock.
- rst_n  in  1  reset, asynchronous, active-low.
- src_req  in  1  request level from source domain (asynchronous to `clk_dest`).
- src_data  in  DATA_W  source data bus; stable from `src_req` rise until `dst_ack` rise seen by source.
- dst_ack  out  1  acknowledge level to source domain, driven directly from a flop (no combinational logic).
- dst_valid  out  1  captured word available.
- dst_data  out  DATA_W  captured word.
- dst_ready  in  1  consumer accepts word when high with `dst_valid`.
- proto_err  out  1  sticky protocol-violation flag.
- xfer_count  out  CNT_W  number of completed 4-phase transfers, wraps modulo 2^CNT_W.

Behaviour:
- Reset (async assert, sync release by system):
  - all synchronizer flops = 0; state = IDLE.
  - `dst_ack` = 0, `dst_valid` = 0, `dst_data` = 0, `proto_err` = 0, `xfer_count` = 0.
- Synchronizer: SYNC_STAGES-deep flop chain on `src_req`; last stage = `req_s`. No logic between stages. Only `req_s` is used by the FSM.
- FSM states (registered outputs):
  - IDLE: `dst_valid`=0, `dst_ack`=0. If `req_s`=1: register `src_data` into `dst_data`, set `dst_valid`=1, go to HOLD.
  - HOLD: `dst_valid`=1, `dst_data` held constant.
    - If `dst_ready`=1: `dst_valid`<=0, `dst_ack`<=1, go to ACK.
    - If `req_s`=0 while in HOLD (source withdrew request): set `proto_err`<=1 and continue the HOLD behaviour (word still delivered, ack still issued).
  - ACK: `dst_ack`=1. When `req_s`=0: `dst_ack`<=0, `xfer_count`<=`xfer_count`+1 (wraps), go to IDLE.
- Data is sampled only on the IDLE->HOLD edge; `src_data` is never sampled elsewhere.
- Latency:
  - `src_req` high meeting setup at edge k -> `req_s` high after edge k+SYNC_STAGES-1 -> `dst_valid`=1 and `dst_data` valid after edge k+SYNC_STAGES.
  - `dst_ready` accepted at edge m -> `dst_ack`=1 after edge m.
  - `src_req` low at edge n -> `dst_ack`=0 after edge n+SYNC_STAGES.
- Throughput: at most one word per full 4-phase cycle. IDLE requires `req_s`=0 from the previous transfer before a new capture, so no double capture of one request.
- `dst_ready` high in IDLE or ACK: ignored.
- `dst_ready` held permanently high: `dst_valid` is high exactly one cycle per transfer.
- Reset mid-transfer (any state): all outputs return to reset values immediately. After release, a still-high `src_req` is treated as a new request once synchronized (the source is responsible for recovery).
- `proto_err` clears only on reset.

Test Plan:
- Basic transfer, SYNC_STAGES=2, `dst_ready`=1: `src_data`=0xA5, raise `src_req` at edge 0 -> `dst_valid`=1 with `dst_data`=0xA5 after edge 2, `dst_ack`=1 after edge 3; drop `src_req` -> `dst_ack`=0 two edges later, `xfer_count`=1.
- Backpressure: `dst_ready`=0 for 10 cycles after `dst_valid` -> `dst_valid`/`dst_data` held, `dst_ack` stays 0 and `src_data` changes ignored; `dst_ready`=1 -> ack next edge.
- Back-to-back: 5 full handshakes with data 0x01..0x05 -> five `dst_valid` pulses carrying 0x01..0x05 in order, `xfer_count`=5, `proto_err`=0.
- Protocol violation: drop `src_req` while in HOLD -> `proto_err`=1 (sticky); word still delivered and ack issued; `proto_err` stays 1 across later good transfers.
- Reset mid-HOLD: assert `rst_n`=0 asynchronously between edges -> `dst_valid`, `dst_ack`, `dst_data`, `xfer_count` = 0 immediately, without a clock edge.
- Counter wrap with CNT_W=2: 5 transfers -> `xfer_count` sequence 1,2,3,0,1.
